// File: rtl/traffic_light_ctrl_param.sv
// Two-road traffic light controller with demand-driven greens and a flash mode.
// Ports:
//   clk, reset_n        : clock and asynchronous active-low reset
//   Sa, Sb              : vehicle present on road A / road B
//   flash_en            : request flashing (night/fault) mode
//   Ra, Ya, Ga          : road A lamps
//   Rb, Yb, Gb          : road B lamps
//   state_o             : current state code (debug)
module traffic_light_ctrl_param #(
  parameter int unsigned TW           = 4,
  parameter int unsigned MIN_GREEN    = 4,
  parameter int unsigned MAX_GREEN    = 8,
  parameter int unsigned YELLOW_TIME  = 2,
  parameter int unsigned ALL_RED_TIME = 1,
  parameter int unsigned FLASH_HALF   = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Sa,
  input  logic       Sb,
  input  logic       flash_en,
  output logic       Ra,
  output logic       Ya,
  output logic       Ga,
  output logic       Rb,
  output logic       Yb,
  output logic       Gb,
  output logic [2:0] state_o
);

  localparam int unsigned LAMP_W = 6;

  // Last timer value of each dwell; transitions fire on these.
  localparam logic [TW-1:0] MIN_LAST    = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_LAST    = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] RED_LAST    = TW'(ALL_RED_TIME - 1);
  localparam logic [TW-1:0] FLASH_LAST  = TW'(FLASH_HALF - 1);
  localparam logic [TW-1:0] TIMER_MAX   = '1;

  // Lamp vector order: {Ra, Ya, Ga, Rb, Yb, Gb}
  localparam logic [LAMP_W-1:0] LAMPS_RESET = 6'b001100;

  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    RED_AB   = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    RED_BA   = 3'd5,
    FLASH    = 3'd6
  } state_t;

  state_t              state, state_next;
  logic [TW-1:0]       timer, timer_next;
  logic                phase, phase_next;
  logic                timer_clr;
  logic [LAMP_W-1:0]   lamps, lamps_next;

  // State, timer, flash phase and lamp registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= A_GREEN;
      timer <= '0;
      phase <= 1'b0;
      lamps <= LAMPS_RESET;
    end else begin
      state <= state_next;
      timer <= timer_next;
      phase <= phase_next;
      lamps <= lamps_next;
    end
  end

  // Next-state, flash phase and timer-clear decision
  always_comb begin
    state_next = state;
    phase_next = 1'b0;
    timer_clr  = 1'b0;
    case (state)
      A_GREEN: begin
        if (flash_en || ((timer >= MIN_LAST) && Sb)) state_next = A_YELLOW;
      end
      A_YELLOW: begin
        if (timer == YELLOW_LAST) state_next = RED_AB;
      end
      RED_AB: begin
        if (timer == RED_LAST) state_next = flash_en ? FLASH : B_GREEN;
      end
      B_GREEN: begin
        if (flash_en || ((timer >= MIN_LAST) && (!Sb || Sa)) || (timer == MAX_LAST))
          state_next = B_YELLOW;
      end
      B_YELLOW: begin
        if (timer == YELLOW_LAST) state_next = RED_BA;
      end
      RED_BA: begin
        if (timer == RED_LAST) state_next = flash_en ? FLASH : A_GREEN;
      end
      FLASH: begin
        phase_next = phase;
        if (!flash_en) begin
          state_next = RED_BA;
        end else if (timer == FLASH_LAST) begin
          phase_next = ~phase;
          timer_clr  = 1'b1;
        end
      end
      default: state_next = A_GREEN;
    endcase
    // Flash always starts with the lit half
    if ((state_next == FLASH) && (state != FLASH)) phase_next = 1'b1;
  end

  // Dwell timer: restarts on state change or flash half-period, else saturates
  always_comb begin
    timer_next = timer;
    if ((state_next != state) || timer_clr) begin
      timer_next = '0;
    end else if (timer != TIMER_MAX) begin
      timer_next = timer + TW'(1);
    end
  end

  // Lamps are decoded from the next state so the registered copy tracks state
  always_comb begin
    lamps_next = '0;
    case (state_next)
      A_GREEN:        lamps_next = 6'b001100;
      A_YELLOW:       lamps_next = 6'b010100;
      RED_AB, RED_BA: lamps_next = 6'b100100;
      B_GREEN:        lamps_next = 6'b100001;
      B_YELLOW:       lamps_next = 6'b100010;
      FLASH:          lamps_next = {1'b0, phase_next, 1'b0, phase_next, 2'b00};
      default:        lamps_next = '0;
    endcase
  end

  assign {Ra, Ya, Ga, Rb, Yb, Gb} = lamps;
  assign state_o = state;

endmodule

// File: doc/traffic_light_ctrl_param.md
TRAFFIC_LIGHT_CTRL_PARAM -- requirements
Module: traffic_light_ctrl_param

Interface
REQ-001 SHALL have parameter TW, default 4: width of the dwell timer.
REQ-002 SHALL have parameter MIN_GREEN, default 4: minimum green dwell, in cycles.
REQ-003 SHALL have parameter MAX_GREEN, default 8: maximum B-green dwell, in cycles.
REQ-004 SHALL have parameter YELLOW_TIME, default 2: yellow dwell, in cycles.
REQ-005 SHALL have parameter ALL_RED_TIME, default 1: all-red clearance dwell, in cycles.
REQ-006 SHALL have parameter FLASH_HALF, default 3: flash half-period, in cycles.
REQ-007 SHALL have these ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- Sa  input  1  vehicle present on road A.
- Sb  input  1  vehicle present on road B.
- flash_en  input  1  request for flashing (night/fault) mode.
- Ra, Ya, Ga  output  1 each  road A lamps.
- Rb, Yb, Gb  output  1 each  road B lamps.
- state_o  output  3  current state code, for debug.
REQ-008 SHALL restrict legal parameters to: all durations >=1, MAX_GREEN>=MIN_GREEN, every duration <= 2**TW-1; behaviour outside these limits is undefined.

Function
REQ-009 SHALL be a Moore FSM; lamps and state_o SHALL decode from registered state and flash phase only, with no combinational path from inputs.
REQ-010 SHALL use these states and codes: A_GREEN=0, A_YELLOW=1, RED_AB=2, B_GREEN=3, B_YELLOW=4, RED_BA=5, FLASH=6; codes 7 and unused SHALL recover to A_GREEN on the next edge.
REQ-011 SHALL drive lamps as follows:
- A_GREEN: Ga and Rb high.
- A_YELLOW: Ya and Rb high.
- RED_AB, RED_BA: Ra and Rb high.
- B_GREEN: Ra and Gb high.
- B_YELLOW: Ra and Yb high.
- FLASH: Ya = Rb = flash_phase.
- All other lamps low in every state.
REQ-012 SHALL hold timer at 0 in the first cycle of every state, increment it each cycle, saturate it at 2**TW-1, and clear it on every state change.
REQ-013 SHALL, in a fixed-duration state of duration D, transition on the edge where timer==D-1, so the state is occupied exactly D cycles.
REQ-014 SHALL, in A_GREEN, go to A_YELLOW when flash_en=1 (ignoring MIN_GREEN) or when timer>=MIN_GREEN-1 and Sb=1; otherwise A_GREEN SHALL hold indefinitely.
REQ-015 SHALL, in B_GREEN, go to B_YELLOW on the first of: flash_en=1; timer>=MIN_GREEN-1 and (Sb=0 or Sa=1); timer==MAX_GREEN-1.
REQ-016 SHALL sequence fixed-duration states as: A_YELLOW (YELLOW_TIME) -> RED_AB; B_YELLOW (YELLOW_TIME) -> RED_BA.
REQ-017 SHALL, at the end of RED_AB or RED_BA (ALL_RED_TIME), go to FLASH if flash_en=1; otherwise RED_AB SHALL go to B_GREEN and RED_BA SHALL go to A_GREEN.
REQ-018 SHALL set flash_phase=1 on entry to FLASH and toggle it (clearing timer) on each edge where timer==FLASH_HALF-1.
REQ-019 SHALL, in FLASH, go to RED_BA on the first edge where flash_en=0, so flash exits via all-red to A_GREEN.
REQ-020 SHALL never switch either road directly from green to red or from green to the other road's green; every green SHALL be followed by yellow and then all-red.
REQ-021 SHALL sample inputs only at the clock edge; a glitch between edges SHALL have no effect.

Reset
REQ-022 SHALL, while reset_n=0, immediately (asynchronously) force state=A_GREEN, timer=0, flash_phase=0, giving Ga=1, Rb=1, all other lamps 0, and state_o=0.
REQ-023 SHALL have a reset asserted mid-sequence (any state, any timer value) override everything, and SHALL resume from A_GREEN with a full MIN_GREEN count after release.

Verification (defaults)
REQ-024 Reset, Sa=Sb=flash_en=0 for 30 cycles -> state_o=0 throughout; Ga=Rb=1.
REQ-025 Reset, then Sb=1 and Sa=0 held -> A_GREEN 4, A_YELLOW 2, RED_AB 1, B_GREEN 8 (MAX cap), B_YELLOW 2, RED_BA 1, then A_GREEN, cycle-exact.
REQ-026 In B_GREEN, Sa=1 at timer=1 -> B_GREEN held until timer=3, B_YELLOW on the next cycle (total 4 B_GREEN cycles); Sb=0 at timer=5 -> B_YELLOW after 6 cycles.
REQ-027 flash_en=1 at A_GREEN timer=1 -> A_YELLOW 2, RED_AB 1, FLASH; Ya/Rb toggle 1,0,1 every 3 cycles with Ra=Ga=Yb=Gb=0; flash_en=0 -> RED_BA 1 cycle, then A_GREEN.
REQ-028 reset_n pulsed low at B_GREEN timer=5 -> Ga=1, Rb=1, state_o=0 before the next edge; after release, Sb=1 held -> A_YELLOW after exactly 4 cycles.
REQ-029 Check on every cycle that Ga, Ya and any of Gb/Yb are never high together, and that each road has exactly one lamp lit outside FLASH.
